// File: rtl/emu_bridge_pkg.sv
// Shared definitions for the emulation UART bridge.
// Holds the command codes, reply codes and the command FSM state type.
package emu_bridge_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] ACK   = 8'hA5;
    localparam logic [7:0] NAK   = 8'h3F;

    typedef enum logic [3:0] {
        IDLE,
        W_COLLECT,
        W_LOAD,
        S_COUNT,
        S_HIGH,
        S_LOW,
        G_CAPTURE,
        G_ADDR,
        G_WAIT,
        G_SEND,
        REPLY
    } state_t;

endpackage

// File: rtl/emu_uart_core.sv
// 8N1 UART receiver and transmitter, DIV clk cycles per bit.
// Ports: clk, reset, rxd, txd, rx_data/rx_valid, tx_data/tx_valid/tx_ready.
module emu_uart_core #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       rx_state;
    logic            rx_s1, rx_s2, rx_q;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_q     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_q     <= rx_s2;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_q && !rx_s2)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        // A glitch shorter than half a bit is not a start.
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic [9:0]    tx_shift;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_busy;
    logic          tx_last;

    // Accepting during the final stop-bit cycle keeps frames gapless.
    assign tx_last  = tx_busy && (tx_cnt == LAST) && (tx_bit == 4'd9);
    assign tx_ready = !tx_busy || tx_last;
    assign txd      = tx_shift[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            tx_shift <= {1'b1, tx_data, 1'b0};
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_cnt == LAST) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bit   <= tx_bit + 1'b1;
                if (tx_bit == 4'd9)
                    tx_busy <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/emu_uart_bridge.sv
// Host UART transactor driving the co-emulation wrapper bus.
// Ports: clk, reset, rxd, txd, Din/Addr/load/get/Dout_emu, clk_dut, busy.
module emu_uart_bridge
    import emu_bridge_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int NUM_STIM    = 5,
    parameter int NUM_OUT     = 3,
    parameter int TIMEOUT_CYC = 16 * 10 * (CLK_HZ / BAUD)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] Din_emu,
    output logic [2:0] Addr_emu,
    output logic       load_emu,
    output logic       get_emu,
    input  logic [7:0] Dout_emu,
    output logic       clk_dut,
    output logic       busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [7:0] rx_data, tx_data;
    logic       rx_valid, tx_valid, tx_ready;

    emu_uart_core #(.DIV(DIV)) u_core (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .txd      (txd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [8:0]    steps, steps_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [7:0]    reply, reply_n;
    logic [7:0]    cap, cap_n;
    logic [7:0]    din_n;
    logic [2:0]    addr_n;
    logic          load_n, get_n, clk_n;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            steps    <= '0;
            tmo      <= '0;
            reply    <= '0;
            cap      <= '0;
            Din_emu  <= '0;
            Addr_emu <= '0;
            load_emu <= 1'b0;
            get_emu  <= 1'b0;
            clk_dut  <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            steps    <= steps_n;
            tmo      <= tmo_n;
            reply    <= reply_n;
            cap      <= cap_n;
            Din_emu  <= din_n;
            Addr_emu <= addr_n;
            load_emu <= load_n;
            get_emu  <= get_n;
            clk_dut  <= clk_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        steps_n  = steps;
        tmo_n    = '0;
        reply_n  = reply;
        cap_n    = cap;
        din_n    = Din_emu;
        addr_n   = Addr_emu;
        load_n   = 1'b0;
        get_n    = 1'b0;
        clk_n    = clk_dut;
        tx_valid = 1'b0;
        tx_data  = reply;
        case (state)
            IDLE: begin
                clk_n = 1'b0;
                if (rx_valid) begin
                    case (rx_data)
                        CMD_W: begin
                            idx_n   = '0;
                            state_n = W_COLLECT;
                        end
                        CMD_S: state_n = S_COUNT;
                        CMD_G: begin
                            get_n   = 1'b1;
                            state_n = G_CAPTURE;
                        end
                        default: begin
                            reply_n = NAK;
                            state_n = REPLY;
                        end
                    endcase
                end
            end
            W_COLLECT: begin
                if (rx_valid) begin
                    din_n  = rx_data;
                    addr_n = idx;
                    if (idx == 3'(NUM_STIM - 1))
                        state_n = W_LOAD;
                    else
                        idx_n = idx + 1'b1;
                end else begin
                    tmo_n = tmo + 1'b1;
                    if (tmo == TMO_LAST)
                        state_n = IDLE;
                end
            end
            W_LOAD: begin
                load_n  = 1'b1;
                reply_n = ACK;
                state_n = REPLY;
            end
            S_COUNT: begin
                if (rx_valid) begin
                    // A count of zero encodes 256 steps.
                    steps_n = {rx_data == 8'd0, rx_data};
                    clk_n   = 1'b1;
                    state_n = S_HIGH;
                end else begin
                    tmo_n = tmo + 1'b1;
                    if (tmo == TMO_LAST)
                        state_n = IDLE;
                end
            end
            S_HIGH: begin
                clk_n   = 1'b0;
                steps_n = steps - 1'b1;
                state_n = S_LOW;
            end
            S_LOW: begin
                if (steps == 9'd0) begin
                    reply_n = ACK;
                    state_n = REPLY;
                end else begin
                    clk_n   = 1'b1;
                    state_n = S_HIGH;
                end
            end
            G_CAPTURE: begin
                idx_n   = '0;
                addr_n  = '0;
                state_n = G_ADDR;
            end
            // Wrapper registers the read in G_ADDR; sample it after G_WAIT.
            G_ADDR: state_n = G_WAIT;
            G_WAIT: begin
                cap_n   = Dout_emu;
                state_n = G_SEND;
            end
            G_SEND: begin
                tx_valid = 1'b1;
                tx_data  = cap;
                if (tx_ready) begin
                    if (idx == 3'(NUM_OUT - 1)) begin
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        addr_n  = idx + 1'b1;
                        state_n = G_ADDR;
                    end
                end
            end
            REPLY: begin
                tx_valid = 1'b1;
                if (tx_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_emu_uart_bridge.sv
// Directed bench for emu_uart_bridge with a small wrapper model.
// Drives UART frames on rxd and decodes bytes from txd.
module tb_emu_uart_bridge;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic       txd;
    logic [7:0] Din_emu;
    logic [2:0] Addr_emu;
    logic       load_emu;
    logic       get_emu;
    logic [7:0] Dout_emu;
    logic       clk_dut;
    logic       busy;

    emu_uart_bridge #(
        .CLK_HZ   (1_000_000),
        .BAUD     (100_000),
        .NUM_STIM (5),
        .NUM_OUT  (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .txd      (txd),
        .Din_emu  (Din_emu),
        .Addr_emu (Addr_emu),
        .load_emu (load_emu),
        .get_emu  (get_emu),
        .Dout_emu (Dout_emu),
        .clk_dut  (clk_dut),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wrapper model: stimulus array written every cycle, registered read.
    logic [7:0] stim [0:7];
    always @(posedge clk) begin
        stim[Addr_emu] <= Din_emu;
        case (Addr_emu)
            3'd0:    Dout_emu <= 8'h02;
            3'd1:    Dout_emu <= 8'h5A;
            3'd2:    Dout_emu <= 8'hC3;
            default: Dout_emu <= 8'h00;
        endcase
    end

    int         load_cnt = 0, get_cnt = 0, pulse_cnt = 0;
    int         wide_err = 0, both_err = 0, chg_err = 0;
    logic       clk_prev = 1'b0;
    logic [2:0] addr_prev = '0;
    logic [39:0] snap = '0;
    logic [2:0] addr_q[$];
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (load_emu) begin
            load_cnt++;
            snap = {stim[0], stim[1], stim[2], stim[3], stim[4]};
        end
        if (get_emu) get_cnt++;
        if (clk_dut && !clk_prev) pulse_cnt++;
        if (clk_dut && clk_prev) wide_err++;
        if (load_emu && get_emu) both_err++;
        if (Addr_emu != addr_prev) begin
            addr_q.push_back(Addr_emu);
            if (load_emu || get_emu) chg_err++;
        end
        clk_prev  = clk_dut;
        addr_prev = Addr_emu;
    end

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                if (txd === 1'b1) rxq.push_back(b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] v, input logic stop_bit);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2 * DIV) @(negedge clk);
    endtask

    function automatic logic [23:0] pop3();
        logic [23:0] r = '0;
        for (int i = 0; i < 3; i++)
            if (rxq.size() > 0) r = {r[15:0], rxq.pop_front()};
        return r;
    endfunction

    function automatic logic [7:0] pop1();
        return (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
    endfunction

    int bl, bg, bp;

    task automatic mark();
        bl = load_cnt;
        bg = get_cnt;
        bp = pulse_cnt;
        rxq.delete();
        addr_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_din", Din_emu, 0);
        chk("rst_addr", Addr_emu, 0);
        chk("rst_load", load_emu, 0);
        chk("rst_get", get_emu, 0);
        chk("rst_clkdut", clk_dut, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        mark();
        send_byte(8'h57, 1);
        send_byte(8'h01, 1);
        send_byte(8'h41, 1);
        send_byte(8'h00, 1);
        send_byte(8'h80, 1);
        send_byte(8'hFF, 1);
        wait_tx(1, 400);
        chk("w_load_cnt", load_cnt - bl, 1);
        chk("w_stim", snap, 40'h01_41_00_80_FF);
        chk("w_ack_cnt", rxq.size(), 1);
        chk("w_ack", pop1(), 8'hA5);
        chk("w_no_get", get_cnt - bg, 0);
        chk("w_busy", busy, 0);

        mark();
        send_byte(8'h53, 1);
        send_byte(8'h03, 1);
        wait_tx(1, 400);
        chk("s3_pulses", pulse_cnt - bp, 3);
        chk("s3_ack", pop1(), 8'hA5);

        mark();
        send_byte(8'h53, 1);
        send_byte(8'h00, 1);
        wait_tx(1, 1200);
        chk("s0_pulses", pulse_cnt - bp, 256);
        chk("s0_ack", pop1(), 8'hA5);
        chk("s_width", wide_err, 0);

        mark();
        send_byte(8'h47, 1);
        wait_tx(3, 800);
        chk("g_get_cnt", get_cnt - bg, 1);
        chk("g_addr_n", addr_q.size(), 3);
        chk("g_addr", (addr_q.size() == 3) ?
            {addr_q[0], addr_q[1], addr_q[2]} : 9'h1FF, 9'o012);
        chk("g_bytes", pop3(), 24'h025AC3);

        mark();
        send_byte(8'h12, 1);
        wait_tx(1, 400);
        chk("nak", pop1(), 8'h3F);
        chk("nak_quiet", (load_cnt - bl) + (get_cnt - bg)
            + (pulse_cnt - bp), 0);

        mark();
        send_byte(8'h57, 1);
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        repeat (2000) @(negedge clk);
        chk("tmo_load", load_cnt - bl, 0);
        chk("tmo_reply", rxq.size(), 0);
        chk("tmo_busy", busy, 0);
        send_byte(8'h47, 1);
        wait_tx(3, 800);
        chk("tmo_g_bytes", pop3(), 24'h025AC3);

        mark();
        send_byte(8'h47, 0);
        repeat (300) @(negedge clk);
        chk("frm_get", get_cnt - bg, 0);
        chk("frm_reply", rxq.size(), 0);
        chk("frm_busy", busy, 0);

        mark();
        send_byte(8'h53, 1);
        send_byte(8'hFF, 1);
        repeat (21) @(negedge clk);
        chk("rs_running", (pulse_cnt - bp) > 5, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rs_clkdut", clk_dut, 0);
        chk("rs_txd", txd, 1);
        chk("rs_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        chk("both_high", both_err, 0);
        chk("addr_chg", chg_err, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
